// File: rtl/u_32b_div_if.sv
`default_nettype none
// ============================================================================
// Module      : u_32b_div_if
// Description : Request/response bundle for the 32-bit unsigned divider.
//               The master issues start/in1/in2. The slave (the divider)
//               returns busy/done and the results.
// Revision    : 1.0 - initial release
// ============================================================================
interface u_32b_div_if;
  logic        start;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_by_zero;

  modport master (
    output start, in1, in2,
    input  busy, done, quot, rem, div_by_zero
  );

  modport slave (
    input  start, in1, in2,
    output busy, done, quot, rem, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/u_32b_div.sv
`default_nettype none
// ============================================================================
// Module      : u_32b_div
// Description : 32-bit unsigned restoring divider. It retires one quotient
//               bit per clock, MSB first, so a nonzero divisor takes 32 RUN
//               cycles. A zero divisor completes at once with
//               quot=all-ones, rem=dividend and div_by_zero=1.
// Revision    : 1.0 - initial release
// ============================================================================
module u_32b_div (
  input  logic        clk,
  input  logic        rst,
  u_32b_div_if.slave  div_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_STEP = 5'd31;

  state_t      state_q;
  logic [31:0] dvd_q;    // dividend bits still to consume; quotient bits shift in at the bottom
  logic [31:0] dvs_q;    // latched divisor
  logic [31:0] prem_q;   // partial remainder
  logic [4:0]  cnt_q;    // steps already completed
  logic [31:0] quot_q;
  logic [31:0] rem_q;
  logic        dbz_q;
  logic        busy_q;
  logic        done_q;

  logic [32:0] shifted_d;
  logic        borrow_d;
  logic [31:0] prem_d;
  logic [31:0] dvd_d;

  // One restoring step. The 33-bit compare detects the borrow. When there is
  // no borrow, the true difference is below the divisor and fits in 32 bits,
  // so a 32-bit subtract yields it exactly.
  always_comb begin
    shifted_d = {prem_q, dvd_q[31]};
    borrow_d  = (shifted_d < {1'b0, dvs_q});
    prem_d    = borrow_d ? shifted_d[31:0] : (shifted_d[31:0] - dvs_q);
    dvd_d     = {dvd_q[30:0], ~borrow_d};
  end

  // Control FSM, datapath and registered outputs. Reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (div_if.start) begin
            dvd_q  <= div_if.in1;
            dvs_q  <= div_if.in2;
            prem_q <= '0;
            cnt_q  <= '0;
            if (div_if.in2 == 32'd0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              quot_q  <= '1;
              rem_q   <= div_if.in1;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          prem_q <= prem_d;
          dvd_q  <= dvd_d;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == LAST_STEP) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= dvd_d;
            rem_q   <= prem_d;
            dbz_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign div_if.busy        = busy_q;
  assign div_if.done        = done_q;
  assign div_if.quot        = quot_q;
  assign div_if.rem         = rem_q;
  assign div_if.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_u_32b_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_u_32b_div
// Description : Self-checking bench for u_32b_div. Each request pushes its
//               expected result onto a scoreboard. A negedge monitor pops and
//               compares an entry on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_u_32b_div;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  u_32b_div_if bus ();

  u_32b_div dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (bus)
  );

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: busy/done exclusivity, plus a scoreboard compare on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.busy || bus.done))
      check("busy_done_excl", {63'd0, bus.busy & bus.done}, 64'd0);
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("quot", {32'd0, bus.quot}, {32'd0, e.q});
        check("rem",  {32'd0, bus.rem},  {32'd0, e.r});
        check("dbz",  {63'd0, bus.div_by_zero}, {63'd0, e.z});
      end
    end
  end

  // Call this at a negedge with busy=0. It returns at the negedge where done is
  // seen, so the caller can issue the next start in the DONE cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input bit noise, input int exp_lat);
    exp_t e;
    int   lat;
    int   bcnt;
    bus.in1   = a;
    bus.in2   = b;
    bus.start = 1'b1;
    e.q = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    e.r = (b == 32'd0) ? a : a % b;
    e.z = (b == 32'd0);
    sb.push_back(e);
    lat  = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.busy) bcnt++;
      if (noise && lat < 28) begin
        bus.start = 1'($urandom);
        bus.in1   = $urandom;
        bus.in2   = $urandom;
      end else begin
        bus.start = 1'b0;
      end
    end while (!bus.done && lat < 40);
    check("done_seen", {63'd0, bus.done}, 64'd1);
    check("latency",   64'(lat),  64'(exp_lat));
    check("busy_cnt",  64'(bcnt), 64'(exp_lat - 1));
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_quot", {32'd0, bus.quot}, 64'd0);
    check("rst_rem",  {32'd0, bus.rem},  64'd0);
    check("rst_dbz",  {63'd0, bus.div_by_zero}, 64'd0);
    rst = 1'b0;

    // Basic divide.
    @(negedge clk);
    run_op(32'd10, 32'd5, 1'b0, 33);

    // Back-to-back requests, each started in the DONE cycle of the previous one.
    @(negedge clk);
    run_op(32'd100, 32'd99, 1'b0, 33);
    run_op(32'd1000, 32'd1010, 1'b0, 33);
    run_op(32'd1073409, 32'd80675, 1'b0, 33);

    // Divide by zero, followed back-to-back by all-ones / 1.
    @(negedge clk);
    run_op(32'd7, 32'd0, 1'b0, 1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 33);

    // Toggle start and change operands during RUN; both must be ignored.
    @(negedge clk);
    run_op(32'd50, 32'd3, 1'b1, 33);

    // Reset at RUN step 10 aborts the request; no done may follow.
    @(negedge clk);
    bus.in1   = 32'd50;
    bus.in2   = 32'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_quot", {32'd0, bus.quot}, 64'd0);
    check("abort_rem",  {32'd0, bus.rem},  64'd0);
    check("abort_dbz",  {63'd0, bus.div_by_zero}, 64'd0);
    repeat (40) @(negedge clk);
    run_op(32'd9, 32'd4, 1'b0, 33);

    // Random pairs with corner values mixed in; some back-to-back, some with a gap.
    for (int i = 0; i < 1200; i++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'd0;
        1:       a = 32'd1;
        2:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(2, 255));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      run_op(a, b, 1'b0, (b == 32'd0) ? 1 : 33);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
